// File: rtl/sha256_pkg.sv
// Shared constants and FSM state type for the SHA-256 message padder.
package sha256_pkg;

  localparam int BLOCK_BITS     = 512;
  localparam int LEN_FIELD_BITS = 64;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    EMIT,
    DONE
  } state_e;

endpackage

// File: rtl/sha256_block_former.sv
// Combinational former: builds the whole padded stream byte by byte and selects one 512-bit block.
module sha256_block_former
  import sha256_pkg::*;
#(
  parameter int MAX_MSG_BYTES = 80,
  parameter int IDX_W         = 2,
  parameter int LEN_W         = 7
) (
  input  logic [8*MAX_MSG_BYTES-1:0] msg_i,
  input  logic [LEN_W-1:0]           len_i,
  input  logic [IDX_W-1:0]           nblk_i,
  input  logic [IDX_W-1:0]           idx_i,
  output logic [BLOCK_BITS-1:0]      block_o
);

  localparam int MAX_BLOCKS   = (MAX_MSG_BYTES + 8) / 64 + 1;
  localparam int STREAM_BYTES = 64 * MAX_BLOCKS;
  localparam int STREAM_BITS  = 8 * STREAM_BYTES;

  logic [LEN_FIELD_BITS-1:0] len64;
  logic [LEN_FIELD_BITS-1:0] bit_len;
  logic [LEN_FIELD_BITS-1:0] len_base;
  logic [STREAM_BITS-1:0]    stream;

  assign len64    = LEN_FIELD_BITS'(len_i);
  assign bit_len  = len64 << 3;
  // Start of the length field: last 8 bytes of the final block.
  assign len_base = (LEN_FIELD_BITS'(nblk_i) << 6) - LEN_FIELD_BITS'(8);

  genvar gi;
  generate
    for (gi = 0; gi < STREAM_BYTES; gi++) begin : g_byte
      logic [LEN_FIELD_BITS-1:0] pos;
      logic [LEN_FIELD_BITS-1:0] len_off;
      logic [7:0]                msg_byte;
      logic [7:0]                len_byte;
      logic [7:0]                byte_val;

      assign pos      = LEN_FIELD_BITS'(gi);
      assign len_off  = pos - len_base;
      assign len_byte = 8'(bit_len >> {3'd7 - len_off[2:0], 3'b000});

      if (gi < MAX_MSG_BYTES) begin : g_msg
        assign msg_byte = msg_i[8*MAX_MSG_BYTES-1-8*gi -: 8];
      end else begin : g_nomsg
        assign msg_byte = 8'h00;
      end

      always_comb begin
        byte_val = 8'h00;
        if (pos < len64) begin
          byte_val = msg_byte;
        end else if (pos == len64) begin
          byte_val = PAD_BYTE;
        end else if (len_off < LEN_FIELD_BITS'(8)) begin
          byte_val = len_byte;
        end
      end

      assign stream[STREAM_BITS-1-8*gi -: 8] = byte_val;
    end
  endgenerate

  always_comb begin
    block_o = '0;
    for (int b = 0; b < MAX_BLOCKS; b++) begin
      if (idx_i == IDX_W'(b)) begin
        block_o = stream[STREAM_BITS-1-BLOCK_BITS*b -: BLOCK_BITS];
      end
    end
  end

endmodule

// File: rtl/sha256_pad_streamer.sv
// SHA-256 padder top: latches a message, checks its length and streams padded blocks with valid/ready.
module sha256_pad_streamer
  import sha256_pkg::*;
#(
  parameter  int MAX_MSG_BYTES = 80,
  localparam int MAX_BLOCKS    = (MAX_MSG_BYTES + 8) / 64 + 1,
  localparam int LEN_W         = $clog2(MAX_MSG_BYTES + 1),
  localparam int IDX_W         = $clog2(MAX_BLOCKS + 1)
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [8*MAX_MSG_BYTES-1:0] msg_in,
  input  logic [LEN_W-1:0]           msg_len,
  input  logic                       start,
  output logic                       busy,
  output logic                       len_err,
  output logic [BLOCK_BITS-1:0]      block_out,
  output logic                       block_valid,
  input  logic                       block_ready,
  output logic [IDX_W-1:0]           block_idx,
  output logic                       block_last,
  output logic [IDX_W-1:0]           num_blocks,
  output logic                       done
);

  state_e                     state_q;
  logic [8*MAX_MSG_BYTES-1:0] msg_q;
  logic [LEN_W-1:0]           len_q;
  logic [IDX_W-1:0]           nblk_q;
  logic [IDX_W-1:0]           cnt_q;
  logic                       busy_q;
  logic                       len_err_q;
  logic [BLOCK_BITS-1:0]      block_q;
  logic                       valid_q;
  logic [IDX_W-1:0]           idx_q;
  logic                       last_q;
  logic                       done_q;

  logic [BLOCK_BITS-1:0]      block_d;
  logic [IDX_W-1:0]           nblk_d;
  logic                       len_over;
  logic                       load_next;

  assign len_over  = 32'(len_q) > 32'(MAX_MSG_BYTES);
  assign nblk_d    = IDX_W'((32'(len_q) + 32'd8) / 32'd64 + 32'd1);
  // Load a block when the output register is empty or the current non-final block is taken.
  assign load_next = !valid_q || (block_ready && !last_q);

  sha256_block_former #(
    .MAX_MSG_BYTES (MAX_MSG_BYTES),
    .IDX_W         (IDX_W),
    .LEN_W         (LEN_W)
  ) u_former (
    .msg_i   (msg_q),
    .len_i   (len_q),
    .nblk_i  (nblk_q),
    .idx_i   (cnt_q),
    .block_o (block_d)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      msg_q     <= '0;
      len_q     <= '0;
      nblk_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      len_err_q <= 1'b0;
      block_q   <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            msg_q   <= msg_in;
            len_q   <= msg_len;
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (len_over) begin
            len_err_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            nblk_q  <= nblk_d;
            cnt_q   <= '0;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (load_next) begin
            block_q <= block_d;
            idx_q   <= cnt_q;
            last_q  <= (cnt_q == nblk_q - IDX_W'(1));
            cnt_q   <= cnt_q + IDX_W'(1);
            valid_q <= 1'b1;
          end else if (block_ready) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign len_err     = len_err_q;
  assign block_out   = block_q;
  assign block_valid = valid_q;
  assign block_idx   = idx_q;
  assign block_last  = last_q;
  assign num_blocks  = nblk_q;
  assign done        = done_q;

endmodule

// File: doc/sha256_pad_streamer.md
Name: sha256_pad_streamer

Overview:
- Parametrised SHA-256 message padder for the miner datapath. Sits between the message/header source and the SHA-256 compression core.
- Takes a left-aligned, byte-granular message with an explicit byte length and forms the FIPS 180-4 padded stream: message bytes, then 0x80, then zeros, then the 64-bit big-endian bit length.
- Streams the result one 512-bit block per handshake, with block index and last flag.
- Handles any length up to MAX_MSG_BYTES. Covers single-block (length byte 55 or less) and multi-block cases, including the 56–63 byte overflow case.

Parameters:
- MAX_MSG_BYTES, 80, maximum message length in bytes; 80 is the 640-bit block header.
- MAX_BLOCKS, (MAX_MSG_BYTES+8)/64+1, localparam: worst-case padded block count.
- LEN_W, $clog2(MAX_MSG_BYTES+1), localparam: width of the length input.
- IDX_W, $clog2(MAX_BLOCKS+1), localparam: width of block index and count.

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- msg_in  in  8*MAX_MSG_BYTES  message; byte j = msg_in[8*MAX_MSG_BYTES-1-8j -: 8]
- msg_len  in  LEN_W  message length in bytes
- start  in  1  request; sampled only in IDLE
- busy  out  1  high from start acceptance until DONE exits
- len_err  out  1  one-cycle pulse when msg_len > MAX_MSG_BYTES
- block_out  out  512  current padded block; byte 0 at bits [511:504]
- block_valid  out  1  block_out valid
- block_ready  in  1  consumer accepts block_out when valid && ready
- block_idx  out  IDX_W  index of block_out, starting at 0
- block_last  out  1  block_out is the final block
- num_blocks  out  IDX_W  latched total block count N
- done  out  1  one-cycle pulse after the last block is accepted

Behaviour:
- Reset values: all outputs 0; state IDLE; message, length and counter registers 0. Reset mid-operation aborts with no done and no len_err.
- States: IDLE, CHECK, EMIT, DONE.
- IDLE:
  - On start, latch msg_in and msg_len and go to CHECK.
  - busy rises in the following cycle.
- CHECK (one cycle):
  - If L > MAX_MSG_BYTES: pulse len_err, go to IDLE, emit no blocks.
  - Otherwise compute N = floor((L+8)/64)+1, latch it into num_blocks, clear the block counter and go to EMIT.
- EMIT:
  - block_valid is high; block_out, block_idx and block_last are registered.
  - First valid appears 2 cycles after the start-sampling edge.
  - Padded stream byte p, for p < 64N:
    - p < L: message byte p
    - p == L: 0x80
    - p >= 64N-8: byte (p-(64N-8)) of the 64-bit big-endian value 8L
    - otherwise: 0x00
  - block_out for block b holds bytes 64b..64b+63.
  - Length arithmetic is done in 64 bits; no overflow for legal L.
  - Backpressure: while valid && !ready, block_out, block_idx and block_last hold stable.
  - On a handshake with block_idx < N-1, the next block appears in the next cycle with no bubble.
  - On a handshake with block_last, drop valid and go to DONE.
- DONE: pulse done for one cycle, deassert busy, return to IDLE.
- start is ignored in every state except IDLE, including start in the same cycle as done.
- msg_in and msg_len may change after acceptance; only latched copies are used.
- L = 0 is legal: a single block of 0x80 followed by zeros, length field 0.

Decomposition:
- Shared package sha256_pkg holds:
  - BLOCK_BITS = 512
  - LEN_FIELD_BITS = 64
  - PAD_BYTE = 8'h80
  - the state enum (IDLE, CHECK, EMIT, DONE)
- One combinational sub-module, sha256_block_former. Inputs: latched message, L, N, block index. Output: the 512-bit block, via per-byte selection.
- The top level holds the FSM, counter, handshake and output registers.

Test Plan:
- "abc" (L=3, bytes 61 62 63): N=1. block_out[511:480]=0x61626380, bits [479:64]=0, [63:0]=0x18. block_last=1, idx=0, done 1 cycle after acceptance.
- L=55 vs L=56 (all bytes 0xAA):
  - L=55: N=1, byte55=0x80, length 0x1B8.
  - L=56: N=2. Block0: byte56=0x80, bytes 57–63 = 0. Block1: all zero except [63:0]=0x1C0.
- L=80 (640-bit header), ready held high: N=2. Block1: bytes 0–15 = message bytes 64–79, byte16=0x80, [63:0]=0x280. Blocks on consecutive cycles; last on idx 1.
- Backpressure on the L=80 case: ready low for 3 cycles on each block. Outputs stay stable; exactly 2 handshakes; done only after the second.
- L=81 with MAX_MSG_BYTES=80: len_err pulses 1 cycle after CHECK entry; no block_valid; back to IDLE.
- Reset asserted during block0 valid of an L=80 run: all outputs 0 immediately. A later start with L=3 yields the correct single block.
